simple_bus_master: RTL
======================

// Module: simple_bus_master
// PURPOSE
//  Initiator end of the simple_bus protocol; counterpart of the slave/memory side.
//  Takes single-beat read/write commands over a valid/ready port, arbitrates via req/gnt, issues start,
//  waits for rdy and returns a response (read data or write ack) over a valid/ready port.
//  Sits between a CPU/DMA command source and a simple_bus instance through the master modport signals.
// PARAMETERS
//  ADDR_W          8    address width (matches simple_bus addr)
//  DATA_W          8    data width (matches simple_bus data)
//  TIMEOUT_CYCLES  64   rdy watchdog limit in cycles; used only with SIMPLE_BUS_MASTER_TIMEOUT_EN
// PORTS
//  clk        in   1       clock, all logic on posedge
//  rst_n      in   1       synchronous active-low reset
//  cmd_valid  in   1       command present
//  cmd_ready  out  1       command accepted when valid&ready
//  cmd_mode   in   2       simple_bus_pkg::mode_e: 00 READ, 01 WRITE, 1x reserved
//  cmd_addr   in   ADDR_W  target address
//  cmd_wdata  in   DATA_W  write data (ignored for READ)
//  rsp_valid  out  1       response present
//  rsp_ready  in   1       response consumed when valid&ready
//  rsp_rdata  out  DATA_W  read data; 0 for WRITE/error
//  rsp_err    out  1       1 = reserved mode or timeout
//  req        out  1       bus request
//  gnt        in   1       bus grant
//  start      out  1       transfer strobe, one cycle
//  addr       out  ADDR_W  bus address
//  mode       out  2       bus mode
//  data_o     out  DATA_W  write data driven to the shared data bus
//  data_oe    out  1       1 = drive data_o onto the data bus (WRITE only)
//  data_i     in   DATA_W  shared data bus value (read return)
//  rdy        in   1       slave completion
// BEHAVIOUR
//  - All outputs registered. Reset: cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req=0, start=0,
//    addr=0, mode=0, data_o=0, data_oe=0; FSM=IDLE. cmd_ready rises the cycle after reset deasserts.
//  - FSM IDLE -> REQ -> START -> WAIT -> RESP -> IDLE.
//  - IDLE: cmd_ready=1. On handshake, latch mode/addr/wdata, drop cmd_ready. Mode 1x -> RESP with
//    rsp_err=1, no bus activity. Otherwise req=1 next cycle -> REQ.
//  - REQ: hold req=1 until gnt=1 is sampled; no bound on gnt wait. Next cycle -> START.
//  - START: start=1 for exactly one cycle; addr/mode driven from latch. data_oe=1 and data_o=wdata for
//    WRITE. addr/mode/data_oe stay stable until rdy is sampled. rdy in START cycle ignored.
//  - WAIT: first rdy=1 sampled ends transfer: READ captures data_i into rsp_rdata; req, data_oe,
//    addr, mode -> 0 next cycle; -> RESP.
//  - RESP: rsp_valid=1, payload stable until rsp_ready; then rsp_valid=0, -> IDLE (cmd_ready=1 that
//    cycle, back-to-back allowed). rsp_ready asserted early has no effect.
//  - Best-case latency cmd handshake -> rsp_valid: 4 cycles, with gnt high and rdy in the first WAIT
//    cycle. gnt dropping after the grant is ignored.
//  - rst_n low mid-transaction: transaction dropped, reset values next edge, no response.
// CONFIGURATION
//  SIMPLE_BUS_MASTER_TIMEOUT_EN defined:
//   - counter clears on entering WAIT.
//   - TIMEOUT_CYCLES WAIT cycles without rdy -> abort: req/data_oe/addr/mode -> 0, RESP with rsp_err=1,
//     rsp_rdata=0.
//   - rdy sampled in the same cycle as expiry wins: normal completion.
//  Not defined: no counter; WAIT lasts until rdy; rsp_err only for reserved mode.
// STRUCTURE
//  simple_bus_pkg holds:
//   - mode_e enum (MODE_READ=2'b00, MODE_WRITE=2'b01)
//   - state_e enum (IDLE, REQ, START, WAIT, RESP)
//   - default ADDR_W/DATA_W localparams
//  Optional sub-module simple_bus_wdog (clear, enable, expired); exists only under the macro.
//  Otherwise a single FSM module.
// TESTING
//  1 Reset: rst_n=0 3 cycles, all inputs random -> every output 0; cmd_ready=1 first cycle after release.
//  2 WRITE addr=0x3C wdata=0xA5, gnt=1, rdy 2 cycles after start:
//    -> req 1 until rdy sampled; start one pulse; addr=0x3C, data_oe=1, data_o=0xA5 until rdy;
//    -> rsp_valid, rsp_err=0, rsp_rdata=0x00.
//  3 READ addr=0x10, gnt delayed 5 cycles, data_i=0x5A with rdy:
//    -> start only after gnt; data_oe=0 throughout; rsp_rdata=0x5A.
//  4 rsp_ready held low 4 cycles -> rsp_valid/payload stable, cmd_ready=0 throughout.
//    On release, next command accepted back-to-back.
//  5 cmd_mode=2'b10 -> req never asserts; rsp_err=1 one cycle after handshake.
//  6 (macro, TIMEOUT_CYCLES=8) rdy never asserted -> after 8 WAIT cycles req drops, rsp_err=1,
//    rsp_rdata=0; repeat with rdy on cycle 8 -> normal completion, rsp_err=0.

Source files
------------

// File: rtl/simple_bus_pkg.sv
// ============================================================================
// Module      : simple_bus_pkg
// Description : Shared types and defaults for the simple_bus master side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package simple_bus_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 8;
    localparam int unsigned DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        MODE_READ  = 2'b00,
        MODE_WRITE = 2'b01
    } mode_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_e;

    // Both 2'b10 and 2'b11 are reserved, so bit 1 alone identifies them.
    function automatic logic mode_is_reserved(input logic [1:0] m);
        return m[1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/simple_bus_wdog.sv
// ============================================================================
// Module      : simple_bus_wdog
// Description : rdy watchdog; only built with SIMPLE_BUS_MASTER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef SIMPLE_BUS_MASTER_TIMEOUT_EN
module simple_bus_wdog #(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // expired_o flags the LIMIT-th enabled cycle so the caller can act on its edge.
    assign expired_o = (count_q == CNT_W'(LIMIT - 1));

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !expired_o) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`endif

`default_nettype wire

// File: rtl/simple_bus_master.sv
// ============================================================================
// Module      : simple_bus_master
// Description : simple_bus initiator: cmd port -> req/gnt/start/rdy -> rsp port.
//               Optional rdy watchdog enabled by SIMPLE_BUS_MASTER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module simple_bus_master
    import simple_bus_pkg::*;
#(
    parameter int unsigned ADDR_W         = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W         = DEFAULT_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mode,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              req,
    input  logic              gnt,
    output logic              start,
    output logic [ADDR_W-1:0] addr,
    output logic [1:0]        mode,
    output logic [DATA_W-1:0] data_o,
    output logic              data_oe,
    input  logic [DATA_W-1:0] data_i,
    input  logic              rdy
);

    state_e            state_q;
    logic [1:0]        lat_mode_q;
    logic [ADDR_W-1:0] lat_addr_q;
    logic [DATA_W-1:0] lat_wdata_q;

    logic              cmd_ready_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic              req_q;
    logic              start_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] data_o_q;
    logic              data_oe_q;

    logic              w_wait_done;
    logic              w_lat_is_write;

    assign w_lat_is_write = (lat_mode_q == MODE_WRITE);

`ifdef SIMPLE_BUS_MASTER_TIMEOUT_EN
    logic w_expired;

    simple_bus_wdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (state_q == START),
        .enable_i  (state_q == WAIT),
        .expired_o (w_expired)
    );

    // rdy in the expiry cycle still counts as a normal completion.
    assign w_wait_done = rdy || w_expired;
`else
    assign w_wait_done = rdy;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lat_mode_q  <= 2'b00;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            req_q       <= 1'b0;
            start_q     <= 1'b0;
            addr_q      <= '0;
            mode_q      <= 2'b00;
            data_o_q    <= '0;
            data_oe_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cmd_ready_q && cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        lat_mode_q  <= cmd_mode;
                        lat_addr_q  <= cmd_addr;
                        lat_wdata_q <= cmd_wdata;
                        if (mode_is_reserved(cmd_mode)) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                            state_q     <= RESP;
                        end else begin
                            req_q   <= 1'b1;
                            state_q <= REQ;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end

                REQ: begin
                    if (gnt) begin
                        start_q   <= 1'b1;
                        addr_q    <= lat_addr_q;
                        mode_q    <= lat_mode_q;
                        data_oe_q <= w_lat_is_write;
                        data_o_q  <= w_lat_is_write ? lat_wdata_q : '0;
                        state_q   <= START;
                    end
                end

                START: begin
                    state_q <= WAIT;
                end

                WAIT: begin
                    if (w_wait_done) begin
                        req_q       <= 1'b0;
                        data_oe_q   <= 1'b0;
                        data_o_q    <= '0;
                        addr_q      <= '0;
                        mode_q      <= 2'b00;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= !rdy;
                        rsp_rdata_q <= (rdy && lat_mode_q == MODE_READ) ? data_i : '0;
                        state_q     <= RESP;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign req       = req_q;
    assign start     = start_q;
    assign addr      = addr_q;
    assign mode      = mode_q;
    assign data_o    = data_o_q;
    assign data_oe   = data_oe_q;

endmodule

`default_nettype wire
